// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: timing record,
// standard mode tables and the configuration register map.
package video_timing_pkg;

    // Timing fields are stored at this fixed width and masked to the counter width on write.
    localparam int FIELD_W = 16;

    typedef struct packed {
        logic [FIELD_W-1:0] h_draw_end;
        logic [FIELD_W-1:0] h_sync_start;
        logic [FIELD_W-1:0] h_sync_end;
        logic [FIELD_W-1:0] h_last;
        logic [FIELD_W-1:0] v_draw_end;
        logic [FIELD_W-1:0] v_sync_start;
        logic [FIELD_W-1:0] v_sync_end;
        logic [FIELD_W-1:0] v_last;
        logic               h_pol;
        logic               v_pol;
    } timing_t;

    typedef enum logic [3:0] {
        REG_H_DRAW_END   = 4'd0,
        REG_H_SYNC_START = 4'd1,
        REG_H_SYNC_END   = 4'd2,
        REG_H_LAST       = 4'd3,
        REG_V_DRAW_END   = 4'd4,
        REG_V_SYNC_START = 4'd5,
        REG_V_SYNC_END   = 4'd6,
        REG_V_LAST       = 4'd7,
        REG_IRQ_LINE     = 4'd8
    } reg_addr_e;

    // Mode tables hold horizontal edges without the pixel-pipeline offset.
    localparam timing_t TIMING_640X480 = '{
        h_draw_end: 16'd640,  h_sync_start: 16'd656,  h_sync_end: 16'd752,  h_last: 16'd799,
        v_draw_end: 16'd480,  v_sync_start: 16'd490,  v_sync_end: 16'd492,  v_last: 16'd524,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam timing_t TIMING_1024X768 = '{
        h_draw_end: 16'd1024, h_sync_start: 16'd1048, h_sync_end: 16'd1184, h_last: 16'd1343,
        v_draw_end: 16'd768,  v_sync_start: 16'd771,  v_sync_end: 16'd777,  v_last: 16'd805,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam timing_t TIMING_1280X720 = '{
        h_draw_end: 16'd1280, h_sync_start: 16'd1390, h_sync_end: 16'd1430, h_last: 16'd1649,
        v_draw_end: 16'd720,  v_sync_start: 16'd725,  v_sync_end: 16'd730,  v_last: 16'd749,
        h_pol: 1'b0, v_pol: 1'b0
    };

    function automatic timing_t with_pixel_delay(timing_t t, int delay);
        timing_t r;
        r              = t;
        r.h_draw_end   = t.h_draw_end   + FIELD_W'(delay);
        r.h_sync_start = t.h_sync_start + FIELD_W'(delay);
        r.h_sync_end   = t.h_sync_end   + FIELD_W'(delay);
        return r;
    endfunction

    function automatic logic in_window(logic [FIELD_W-1:0] n, logic [FIELD_W-1:0] lo,
                                       logic [FIELD_W-1:0] hi);
        return (lo < n) && (n <= hi);
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping position counter plus registered draw/sync windows
// evaluated on the next count, so each window lines up with the count it describes.
module video_timing_axis import video_timing_pkg::*; #(
    parameter int W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               advance_i,
    input  logic [FIELD_W-1:0] last_i,
    input  logic [FIELD_W-1:0] draw_lo_i,
    input  logic [FIELD_W-1:0] draw_hi_i,
    input  logic [FIELD_W-1:0] sync_lo_i,
    input  logic [FIELD_W-1:0] sync_hi_i,
    input  logic               pol_i,
    output logic [W-1:0]       count_o,
    output logic               wrap_o,
    output logic               draw_o,
    output logic               sync_o
);

    logic [W-1:0] count_q, count_d;
    logic         draw_q, draw_d;
    logic         sync_q, sync_d;

    assign wrap_o = enable_i && advance_i && (FIELD_W'(count_q) == last_i);

    always_comb begin
        count_d = count_q;
        if (!enable_i) begin
            count_d = '0;
        end else if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
        draw_d = in_window(FIELD_W'(count_d), draw_lo_i, draw_hi_i);
        sync_d = in_window(FIELD_W'(count_d), sync_lo_i, sync_hi_i) ^ pol_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            draw_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            draw_q  <= draw_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign draw_o  = draw_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-programmable raster timing generator with shadow/active timing registers
// committed at frame boundaries. Define VIDEO_TIMING_LINE_IRQ_EN for the line-compare pulse.
module video_timing_gen import video_timing_pkg::*; #(
    parameter int H_WIDTH     = 11,
    parameter int V_WIDTH     = 10,
    parameter int PIXEL_DELAY = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic               cfg_commit,
    output logic               cfg_pending,
    output logic [H_WIDTH-1:0] h_count,
    output logic [V_WIDTH-1:0] v_count,
    output logic               h_draw,
    output logic               v_draw,
    output logic               draw_area,
    output logic               h_sync,
    output logic               v_sync,
    output logic               line_start,
    output logic               frame_start,
    output logic               line_irq
);

    localparam timing_t            RESET_TIMING = with_pixel_delay(TIMING_640X480, PIXEL_DELAY);
    localparam logic [FIELD_W-1:0] H_MASK = FIELD_W'((32'd1 << H_WIDTH) - 32'd1);
    localparam logic [FIELD_W-1:0] V_MASK = FIELD_W'((32'd1 << V_WIDTH) - 32'd1);

    timing_t shadow_q, shadow_d;
    timing_t active_q, active_d;
    logic    pending_q, pending_d;
    logic    h_wrap, v_wrap, apply;
    logic    unused_wdata;

    assign unused_wdata = ^cfg_wdata[30:FIELD_W];

    // A frame boundary is the last pixel of the last line; while disabled any clock will do.
    assign apply = pending_q && (!enable || v_wrap);

    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            case (cfg_addr)
                REG_H_DRAW_END:   shadow_d.h_draw_end = cfg_wdata[FIELD_W-1:0] & H_MASK;
                REG_H_SYNC_START: begin
                    shadow_d.h_sync_start = cfg_wdata[FIELD_W-1:0] & H_MASK;
                    shadow_d.h_pol        = cfg_wdata[31];
                end
                REG_H_SYNC_END:   shadow_d.h_sync_end = cfg_wdata[FIELD_W-1:0] & H_MASK;
                REG_H_LAST:       shadow_d.h_last     = cfg_wdata[FIELD_W-1:0] & H_MASK;
                REG_V_DRAW_END:   shadow_d.v_draw_end = cfg_wdata[FIELD_W-1:0] & V_MASK;
                REG_V_SYNC_START: begin
                    shadow_d.v_sync_start = cfg_wdata[FIELD_W-1:0] & V_MASK;
                    shadow_d.v_pol        = cfg_wdata[31];
                end
                REG_V_SYNC_END:   shadow_d.v_sync_end = cfg_wdata[FIELD_W-1:0] & V_MASK;
                REG_V_LAST:       shadow_d.v_last     = cfg_wdata[FIELD_W-1:0] & V_MASK;
                default: ;
            endcase
        end
        active_d  = apply ? shadow_q : active_q;
        pending_d = cfg_commit || (pending_q && !apply);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= RESET_TIMING;
            active_q  <= RESET_TIMING;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Wrap decisions use the timing in force now; windows use the timing for the next count.
    video_timing_axis #(.W(H_WIDTH)) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .advance_i (1'b1),
        .last_i    (active_q.h_last),
        .draw_lo_i (FIELD_W'(PIXEL_DELAY)),
        .draw_hi_i (active_d.h_draw_end),
        .sync_lo_i (active_d.h_sync_start),
        .sync_hi_i (active_d.h_sync_end),
        .pol_i     (active_d.h_pol),
        .count_o   (h_count),
        .wrap_o    (h_wrap),
        .draw_o    (h_draw),
        .sync_o    (h_sync)
    );

    video_timing_axis #(.W(V_WIDTH)) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable),
        .advance_i (h_wrap),
        .last_i    (active_q.v_last),
        .draw_lo_i ('0),
        .draw_hi_i (active_d.v_draw_end),
        .sync_lo_i (active_d.v_sync_start),
        .sync_hi_i (active_d.v_sync_end),
        .pol_i     (active_d.v_pol),
        .count_o   (v_count),
        .wrap_o    (v_wrap),
        .draw_o    (v_draw),
        .sync_o    (v_sync)
    );

    assign cfg_pending = pending_q;
    assign draw_area   = h_draw & v_draw;
    assign line_start  = enable && (h_count == '0);
    assign frame_start = line_start && (v_count == '0);

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic [FIELD_W-1:0] irq_shadow_q, irq_shadow_d;
    logic [FIELD_W-1:0] irq_active_q, irq_active_d;

    always_comb begin
        irq_shadow_d = irq_shadow_q;
        if (cfg_we && (cfg_addr == REG_IRQ_LINE)) begin
            irq_shadow_d = cfg_wdata[FIELD_W-1:0] & V_MASK;
        end
        irq_active_d = apply ? irq_shadow_q : irq_active_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_shadow_q <= '0;
            irq_active_q <= '0;
        end else begin
            irq_shadow_q <= irq_shadow_d;
            irq_active_q <= irq_active_d;
        end
    end

    assign line_irq = line_start && (FIELD_W'(v_count) == irq_active_q);
`else
    assign line_irq = 1'b0;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, runtime-programmable raster timing generator for the DVI output path.
- Produces h/v counters, draw/sync strobes, line/frame pulses in the pixel clock domain.
- Timing is loaded through double-buffered (shadow/active) registers. A commit takes effect only at a frame boundary, so mode changes never produce a torn frame.
- Sits between the APB-side configuration logic and the pixel pipeline / TMDS encoders.

Parameters:
- H_WIDTH, 11, horizontal counter and timing register width.
- V_WIDTH, 10, vertical counter and timing register width.
- PIXEL_DELAY, 3, pixel-pipeline latency in clocks. The horizontal draw window starts after this count.

Ports:
- clk  in  1  pixel clock (single clock domain).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run counters. When 0: counters held at 0, strobes inactive.
- cfg_we  in  1  shadow register write strobe.
- cfg_addr  in  4  register select.
- cfg_wdata  in  32  write data.
- cfg_commit  in  1  request copy of shadow to active at the next frame boundary.
- cfg_pending  out  1  commit requested but not yet applied.
- h_count  out  H_WIDTH  current horizontal position.
- v_count  out  V_WIDTH  current line.
- h_draw, v_draw, draw_area  out  1  draw windows; draw_area = h_draw & v_draw.
- h_sync, v_sync  out  1  sync outputs, polarity applied.
- line_start  out  1  high when h_count==0 and enable.
- frame_start  out  1  high when h_count==0, v_count==0 and enable.
- line_irq  out  1  line compare pulse (optional feature).

Behaviour:
- Register map (cfg_addr; wdata bits, truncated to width):
  - 0 h_draw_end
  - 1 h_sync_start, plus bit31 h_pol (1 = active-low)
  - 2 h_sync_end
  - 3 h_last
  - 4 v_draw_end
  - 5 v_sync_start, plus bit31 v_pol
  - 6 v_sync_end
  - 7 v_last
  - 8 irq_line (optional feature)
  - Other addresses are ignored.
- Reset values, for both shadow and active registers (640x480):
  - h_draw_end 640+PIXEL_DELAY, h_sync_start 656+PIXEL_DELAY, h_sync_end 752+PIXEL_DELAY, h_last 799
  - v_draw_end 480, v_sync_start 490, v_sync_end 492, v_last 524
  - polarities 0, irq_line 0
  - counters 0, cfg_pending 0, all strobes 0
- Counting: h_count increments each clock while enable. At h_count==h_last it wraps to 0 and v advances; v wraps at v_last.
- Window semantics (all outputs registered, so each holds for the cycle in which the counters have these values):
  - h_draw: PIXEL_DELAY < h_count <= h_draw_end (640 pixels at reset).
  - h_sync_raw: h_sync_start < h_count <= h_sync_end.
  - v_draw: 0 < v_count <= v_draw_end.
  - v_sync_raw: v_sync_start < v_count <= v_sync_end.
  - h_sync = h_sync_raw ^ h_pol; v_sync = v_sync_raw ^ v_pol.
  - Inconsistent settings (e.g. start > last) simply never assert. No error is raised.
- Commit:
  - cfg_commit sets cfg_pending.
  - Apply occurs on the clock where h_count==h_last && v_count==v_last, or on any clock while enable==0.
  - Apply copies shadow to active and clears pending. The next frame uses the new timing from h_count=0.
  - A cfg_we in the apply cycle updates the shadow only; the active copy gets the old shadow value.
  - A cfg_commit in the apply cycle leaves cfg_pending=1.
  - A repeated commit while pending has no extra effect.
- enable falling: on the next edge, counters go to 0, draw/sync_raw go to 0, and sync outputs show the inactive polarity level.
- enable rising: counting starts at (0,0). frame_start is asserted in that first cycle.
- Reset mid-frame: all state goes asynchronously to reset values with no clock edge required. Pending commit is lost.

Optional Feature:
- Macro VIDEO_TIMING_LINE_IRQ_EN.
- Defined: register 8 is writable (shadow/active like the others). line_irq pulses exactly one clock when h_count==0 && v_count==irq_line && enable.
- Undefined: writes to address 8 are ignored and line_irq is constant 0.

Decomposition:
- Package video_timing_pkg holds:
  - typedef struct timing_t with the 8 timing fields and 2 polarity bits;
  - localparam constants for the 640x480, 1024x768 and 1280x720 timing sets;
  - an enum of register addresses.
- One sub-module, video_timing_axis, is instantiated twice (H and V). It holds a counter with wrap at last, plus registered window compare for draw and sync. The advance input is tied to 1 for H and to the H-wrap for V.

Test Plan:
- Reset, enable=1 -> h_count wraps 799 to 0; per line h_draw high 640 clocks (h_count 4..643) and h_sync high 96 clocks (660..755); frame = 420000 clocks; frame_start once per frame.
- Mid-frame shadow writes of 1024x768 values (1027/1051/1187/1343, 768/771/777/805) plus commit at v=100 -> old timing continues; cfg_pending drops at h=799,v=524; next line length 1344 clocks; 768 lines with v_draw high.
- Write addr1 with bit31=1 and commit -> h_sync idles 1 and is low 96 clocks per line starting the next frame.
- enable=0 at h=300 -> next clock h_count=0, v_count=0, draw=0; a commit while disabled applies next clock, so cfg_pending=1 for one cycle only.
- Assert reset at h=500,v=200 between edges -> counters and strobes read 0 immediately; shadow returns to 640x480 values.
- With VIDEO_TIMING_LINE_IRQ_EN, irq_line=100 committed -> a single line_irq pulse per frame at h=0,v=100. Without the macro, line_irq stays 0 for 2 frames.
